keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
Controller that sequences the 3x4 keypad matrix, debounces presses, and assembles keystrokes into a 4-digit BCD entry. It drives the column strobes, samples the row returns once per column dwell, and runs a press/release FSM over whole scan frames. Accepted keys emit a one-cycle event, edit the entry buffer, and '#' commits the entry to the downstream display/compare logic.

Parameters:
SCAN_DIV, 16, prescaler width; one column dwell = 2^SCAN_DIV fin cycles
DEBOUNCE_CNT, 4, consecutive identical frames needed to accept a press or a release (range 1..15)
REPEAT_DELAY, 32, frames held before the first auto-repeat (KEY_REPEAT_EN only)
REPEAT_RATE, 8, frames between subsequent auto-repeats (KEY_REPEAT_EN only)

Ports:
fin  input  1  system clock
rst  input  1  synchronous reset, active-high
touch_key  input  4  row returns, active-high; bit3=row1 (1/2/3), bit0=row4 (*/0/#)
scan_key  output  3  column strobe, one-hot; 100=col1, 010=col2, 001=col3
key_code  output  4  last accepted key: 0-9 digits, 10='*', 11='#', 15=none
key_valid  output  1  one-cycle pulse when key_code is newly accepted
entry  output  16  four BCD digits; [3:0] is the most recent digit
entry_len  output  3  digits held, 0..4
commit  output  1  one-cycle pulse on a valid '#'
commit_value  output  16  entry captured at the last commit
err  output  1  one-cycle pulse when a digit is entered while entry_len==4

Behaviour:
- Reset, synchronous and active-high: prescaler=0, scan_key=100, key_code=15, key_valid=0, entry=0, entry_len=0, commit=0, commit_value=0, err=0, FSM=IDLE, all counters=0. Asserting rst mid-frame or mid-debounce discards all partial state at that edge.
- Tick: asserted on the cycle in which the prescaler equals all-ones. On each tick edge, scan_key rotates 100->010->001->100. Any illegal scan_key value is forced to 100.
- Sampling: on each tick, touch_key is sampled for the column currently driven. The key map is col1={1,4,7,*}, col2={2,5,8,0}, col3={3,6,9,#}, row order from bit3 to bit0.
- Frame result: evaluated at the tick where scan_key==001. raw = the key code if exactly one key was seen across the three columns. raw = NONE if no key was seen, or if any column was not one-hot or non-zero, or if keys appeared in more than one column (ghosting is rejected). The per-frame accumulator then clears.
- FSM, updated only at frame-evaluation edges:
  - IDLE: if raw != NONE, set cand=raw, cnt=1, go to DEBOUNCE. With DEBOUNCE_CNT=1, accept immediately and go to PRESSED.
  - DEBOUNCE: if raw==cand, increment cnt; when cnt reaches DEBOUNCE_CNT, accept the key and go to PRESSED. If raw is NONE, go to IDLE. If raw is a different key, set cand=raw, cnt=1, stay in DEBOUNCE.
  - PRESSED: if raw==cand, stay. Otherwise set cnt=1 when raw is NONE (cnt=0 for a different key) and go to RELEASE.
  - RELEASE: if raw is NONE, increment cnt; at DEBOUNCE_CNT, go to IDLE. If raw==cand, return to PRESSED with no new event. If raw is a different key, reset cnt to 0 (no new acceptance until a full release).
- Accept: on the accepting edge, key_code<=cand and key_valid<=1 for exactly one cycle. Entry effects are applied on the same edge:
  - Digit with entry_len<4: entry<={entry[11:0],digit}, entry_len+1.
  - Digit with entry_len==4: entry unchanged, err pulse.
  - '*': entry=0, entry_len=0.
  - '#' with entry_len>0: commit_value<=entry, commit pulse, entry=0, entry_len=0.
  - '#' with entry_len==0: no commit and no error.
- key_code holds its value between events. Latency from the frame-completing tick edge to key_valid is 0 cycles; key_valid is visible in the cycle after that edge.

Optional Feature:
KEY_REPEAT_EN:
- Defined: in PRESSED, a frame counter runs. After REPEAT_DELAY held frames, re-accept cand, then repeat every REPEAT_RATE frames. Repeats apply to digits only; '*' and '#' never repeat. Each repeat pulses key_valid and applies the entry rules, including err at len 4. The counter clears on leaving PRESSED.
- Undefined: exactly one key_valid per debounced press, and the REPEAT_* parameters are ignored.

Test Plan:
Test configuration: SCAN_DIV=2 (frame = 12 cycles), DEBOUNCE_CNT=3.
- Reset: after rst, scan_key=100, then 010 four cycles later, then 001, then 100. All other outputs stay at their reset values.
- Single press: hold touch_key=0100 only while col2 is driven, for 3 frames. Expect key_valid once, key_code=5, entry=0x0005, entry_len=1. Holding 5 more frames gives no further pulse.
- Bounce: pattern key, none, key, key, key (frames). Expect acceptance only after the final 3 consecutive frames. Release bounce none, key, none, none, none gives no second event.
- Entry: press 1,2,3,4,5 with full releases between. Expect entry=0x1234, len=4, err pulse on '5'. Then '#' gives commit=1, commit_value=0x1234, entry=0, len=0.
- Clear and empty commit: press 7 then '*'. Expect entry=0, len=0. Then '#' gives no commit pulse and key_code=11.
- Ghost and reset: rows active in col1 and col3 within the same frame give no event. Asserting rst during DEBOUNCE, then releasing it and holding the key, requires a full 3 frames again before acceptance.

Source files
------------

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad matrix and entry-result signals of keypad_entry_ctrl.
// master = the controller, slave = the keypad/downstream side.
interface keypad_entry_ctrl_if;
    logic [3:0]  touch_key;
    logic [2:0]  scan_key;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] entry;
    logic [2:0]  entry_len;
    logic        commit;
    logic [15:0] commit_value;
    logic        err;

    modport master (
        input  touch_key,
        output scan_key, key_code, key_valid, entry, entry_len,
               commit, commit_value, err
    );
    modport slave (
        output touch_key,
        input  scan_key, key_code, key_valid, entry, entry_len,
               commit, commit_value, err
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// 3x4 keypad scanner, frame debouncer and 4-digit BCD entry buffer.
// Optional auto-repeat of held digits: define KEY_REPEAT_EN.
module keypad_entry_ctrl #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic                fin,
    input  logic                rst,
    keypad_entry_ctrl_if.master kp
);
    localparam logic [3:0] NONE = 4'd15;
    localparam logic [3:0] STAR = 4'd10;
    localparam logic [3:0] HASH = 4'd11;
    localparam logic [3:0] DB   = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [SCAN_DIV-1:0] prescaler;
    logic [2:0]  scan_key;
    logic        tick, frame_end;
    logic [1:0]  col_idx, row_idx;
    logic [3:0]  col_key, raw;
    logic        col_hit, col_bad;
    logic [1:0]  acc_hits;
    logic        acc_bad;
    logic [3:0]  acc_code;

    state_t      state, state_n;
    logic [3:0]  cand, cand_n, cnt, cnt_n, cnt_inc;
    logic        accept;

    logic [3:0]  key_code;
    logic        key_valid, commit, err;
    logic [15:0] entry, commit_value;
    logic [2:0]  entry_len;

    assign tick      = &prescaler;
    assign frame_end = tick && (scan_key == 3'b001);

    always_ff @(posedge fin) begin
        if (rst) begin
            prescaler <= '0;
            scan_key  <= 3'b100;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (scan_key != 3'b100 && scan_key != 3'b010 && scan_key != 3'b001)
                scan_key <= 3'b100;
            else if (tick)
                scan_key <= {scan_key[0], scan_key[2:1]};
        end
    end

    // Decode the row returns of the column currently strobed.
    always_comb begin
        case (scan_key)
            3'b100:  col_idx = 2'd0;
            3'b010:  col_idx = 2'd1;
            default: col_idx = 2'd2;
        endcase
        case (kp.touch_key)
            4'b1000: row_idx = 2'd0;
            4'b0100: row_idx = 2'd1;
            4'b0010: row_idx = 2'd2;
            default: row_idx = 2'd3;
        endcase
        col_hit = |kp.touch_key;
        col_bad = col_hit && !$onehot(kp.touch_key);
        col_key = NONE;
        if (row_idx != 2'd3)
            col_key = 4'(row_idx) * 4'd3 + 4'(col_idx) + 4'd1;
        else begin
            case (col_idx)
                2'd0:    col_key = STAR;
                2'd1:    col_key = 4'd0;
                default: col_key = HASH;
            endcase
        end
        // Exactly one clean key across the whole frame, otherwise NONE.
        raw = NONE;
        if (!(acc_bad || col_bad) &&
            ((acc_hits == 2'd1 && !col_hit) || (acc_hits == 2'd0 && col_hit)))
            raw = col_hit ? col_key : acc_code;
    end

    always_ff @(posedge fin) begin
        if (rst || frame_end) begin
            acc_hits <= '0;
            acc_bad  <= 1'b0;
            acc_code <= NONE;
        end else if (tick && col_hit) begin
            acc_hits <= (acc_hits == 2'd0) ? 2'd1 : 2'd2;
            acc_bad  <= acc_bad | col_bad;
            acc_code <= col_key;
        end
    end

`ifdef KEY_REPEAT_EN
    logic [15:0] rep_cnt, rep_cnt_n;
    logic        rep_armed, rep_armed_n;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

    always_ff @(posedge fin) begin
        if (rst) begin
            state <= IDLE;
            cand  <= NONE;
            cnt   <= '0;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= rep_cnt_n;
            rep_armed <= rep_armed_n;
`endif
        end
    end

    assign cnt_inc = cnt + 4'd1;

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        accept  = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt_n   = rep_cnt;
        rep_armed_n = rep_armed;
`endif
        if (frame_end) begin
            case (state)
                IDLE: if (raw != NONE) begin
                    cand_n = raw;
                    cnt_n  = 4'd1;
                    if (DB == 4'd1) begin
                        accept  = 1'b1;
                        state_n = PRESSED;
                    end else
                        state_n = DEBOUNCE;
                end
                DEBOUNCE: begin
                    if (raw == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DB) begin
                            accept  = 1'b1;
                            state_n = PRESSED;
                        end
                    end else if (raw == NONE) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cand_n = raw;
                        cnt_n  = 4'd1;
                    end
                end
                PRESSED: begin
                    if (raw == NONE) begin
                        cnt_n   = 4'd1;
                        state_n = (DB == 4'd1) ? IDLE : RELEASE;
                    end else if (raw != cand) begin
                        cnt_n   = '0;
                        state_n = RELEASE;
                    end
`ifdef KEY_REPEAT_EN
                    else begin
                        rep_cnt_n = rep_cnt + 16'd1;
                        if (rep_cnt_n == (rep_armed ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY))) begin
                            rep_cnt_n   = '0;
                            rep_armed_n = 1'b1;
                            accept      = (cand <= 4'd9);
                        end
                    end
`endif
                end
                default: begin
                    if (raw == NONE) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DB) begin
                            cnt_n   = '0;
                            state_n = IDLE;
                        end
                    end else if (raw == cand) begin
                        cnt_n   = '0;
                        state_n = PRESSED;
                    end else
                        cnt_n = '0;
                end
            endcase
        end
`ifdef KEY_REPEAT_EN
        if (state_n != PRESSED) begin
            rep_cnt_n   = '0;
            rep_armed_n = 1'b0;
        end
`endif
    end

    always_ff @(posedge fin) begin
        if (rst) begin
            key_code     <= NONE;
            key_valid    <= 1'b0;
            entry        <= '0;
            entry_len    <= '0;
            commit       <= 1'b0;
            commit_value <= '0;
            err          <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            commit    <= 1'b0;
            err       <= 1'b0;
            if (accept) begin
                key_code  <= cand_n;
                key_valid <= 1'b1;
                if (cand_n <= 4'd9) begin
                    if (entry_len == 3'd4)
                        err <= 1'b1;
                    else begin
                        entry     <= {entry[11:0], cand_n};
                        entry_len <= entry_len + 3'd1;
                    end
                end else if (cand_n == STAR) begin
                    entry     <= '0;
                    entry_len <= '0;
                end else if (cand_n == HASH && entry_len != 3'd0) begin
                    commit_value <= entry;
                    commit       <= 1'b1;
                    entry        <= '0;
                    entry_len    <= '0;
                end
            end
        end
    end

    assign kp.scan_key     = scan_key;
    assign kp.key_code     = key_code;
    assign kp.key_valid    = key_valid;
    assign kp.entry        = entry;
    assign kp.entry_len    = entry_len;
    assign kp.commit       = commit;
    assign kp.commit_value = commit_value;
    assign kp.err          = err;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed vector table, corner sequences and
// randomized key activity checked against a run-length reference model.
module tb_keypad_entry_ctrl;
    logic fin = 1'b0;
    logic rst = 1'b1;
    logic [11:0] mask = '0;
    int checks = 0;
    int errors = 0;

    keypad_entry_ctrl_if bus ();
    keypad_entry_ctrl #(.SCAN_DIV(2), .DEBOUNCE_CNT(3)) dut (.fin(fin), .rst(rst), .kp(bus));

    always #5 fin = ~fin;

    function automatic int key_row(int k);
        if (k >= 1 && k <= 9) return (k - 1) / 3;
        return 3;
    endfunction
    function automatic int key_col(int k);
        if (k >= 1 && k <= 9) return (k - 1) % 3;
        if (k == 0) return 1;
        if (k == 10) return 0;
        return 2;
    endfunction

    // Physical keypad: pressed keys in the strobed column pull their rows high.
    always_comb begin
        int c;
        bus.touch_key = '0;
        case (bus.scan_key)
            3'b100:  c = 0;
            3'b010:  c = 1;
            3'b001:  c = 2;
            default: c = 3;
        endcase
        for (int k = 0; k < 12; k++)
            if (mask[k] && key_col(k) == c) bus.touch_key[3 - key_row(k)] = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One 12-cycle scan frame; counts pulses seen at each negedge.
    task automatic run_frame(input logic [11:0] m, output int kv, output int cm, output int er);
        mask = m;
        kv = 0; cm = 0; er = 0;
        repeat (12) begin
            @(posedge fin);
            @(negedge fin);
            kv += int'(bus.key_valid);
            cm += int'(bus.commit);
            er += int'(bus.err);
        end
    endtask

    task automatic do_reset();
        @(negedge fin);
        mask = '0;
        rst = 1'b1;
        repeat (2) @(negedge fin);
        rst = 1'b0;
    endtask

    function automatic logic [11:0] kmask(int k);
        logic [11:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    // Reference model: a key is accepted after 3 identical single-key frames
    // while unlocked; acceptance locks until 3 consecutive empty frames.
    bit m_locked;
    int m_nonerun, m_skey, m_streak, m_code, m_cv;
    int m_q[$];

    function automatic int m_entry();
        int v = 0;
        foreach (m_q[i]) v = v * 16 + m_q[i];
        return v;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_nonerun = 0; m_skey = 15; m_streak = 0;
        m_code = 15; m_cv = 0;
        m_q.delete();
    endtask

    task automatic model_frame(input logic [11:0] m, output int acc, output int cm, output int er);
        int raw;
        acc = 0; cm = 0; er = 0;
        raw = ($countones(m) == 1) ? $clog2(int'(m)) : 15;
        if (m_locked) begin
            m_nonerun = (raw == 15) ? m_nonerun + 1 : 0;
            if (m_nonerun >= 3) begin
                m_locked = 0;
                m_streak = 0;
            end
        end else begin
            if (raw == 15) m_streak = 0;
            else if (raw == m_skey && m_streak > 0) m_streak++;
            else begin
                m_skey = raw;
                m_streak = 1;
            end
            if (m_streak == 3) begin
                acc = 1;
                m_locked = 1;
                m_nonerun = 0;
                m_code = raw;
                if (raw <= 9) begin
                    if (m_q.size() == 4) er = 1;
                    else m_q.push_back(raw);
                end else if (raw == 10) m_q.delete();
                else if (m_q.size() > 0) begin
                    m_cv = m_entry();
                    cm = 1;
                    m_q.delete();
                end
            end
        end
    endtask

    typedef struct {
        int key;
        int exp_code;
        int exp_entry;
        int exp_len;
        int exp_commit;
        int exp_cv;
        int exp_err;
    } vec_t;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[9];
        int kv, cm, er, tkv, tcm, ter, acc, ecm, eer;
        logic [11:0] cur;

        vecs[0] = '{1,  1,  'h1,    1, 0, 0,      0};
        vecs[1] = '{2,  2,  'h12,   2, 0, 0,      0};
        vecs[2] = '{3,  3,  'h123,  3, 0, 0,      0};
        vecs[3] = '{4,  4,  'h1234, 4, 0, 0,      0};
        vecs[4] = '{5,  5,  'h1234, 4, 0, 0,      1};
        vecs[5] = '{11, 11, 0,      0, 1, 'h1234, 0};
        vecs[6] = '{7,  7,  'h7,    1, 0, 'h1234, 0};
        vecs[7] = '{10, 10, 0,      0, 0, 'h1234, 0};
        vecs[8] = '{11, 11, 0,      0, 0, 'h1234, 0};

        // Reset state and column rotation
        do_reset();
        check("rst_scan", int'(bus.scan_key), 3'b100);
        check("rst_code", int'(bus.key_code), 15);
        check("rst_entry", int'(bus.entry), 0);
        check("rst_len", int'(bus.entry_len), 0);
        check("rst_cv", int'(bus.commit_value), 0);
        tkv = 0; tcm = 0; ter = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge fin);
            @(negedge fin);
            tkv += int'(bus.key_valid); tcm += int'(bus.commit); ter += int'(bus.err);
            if (i == 3)  check("scan_c3", int'(bus.scan_key), 3'b100);
            if (i == 4)  check("scan_c4", int'(bus.scan_key), 3'b010);
            if (i == 8)  check("scan_c8", int'(bus.scan_key), 3'b001);
            if (i == 12) check("scan_c12", int'(bus.scan_key), 3'b100);
        end
        check("rst_pulses", tkv + tcm + ter, 0);

        // Entry/commit/clear vector table
        for (int v = 0; v < 9; v++) begin
            tkv = 0; tcm = 0; ter = 0;
            for (int f = 0; f < 6; f++) begin
                run_frame((f < 3) ? kmask(vecs[v].key) : 12'h000, kv, cm, er);
                tkv += kv; tcm += cm; ter += er;
            end
            check($sformatf("vec%0d_valid", v), tkv, 1);
            check($sformatf("vec%0d_code", v), int'(bus.key_code), vecs[v].exp_code);
            check($sformatf("vec%0d_entry", v), int'(bus.entry), vecs[v].exp_entry);
            check($sformatf("vec%0d_len", v), int'(bus.entry_len), vecs[v].exp_len);
            check($sformatf("vec%0d_commit", v), tcm, vecs[v].exp_commit);
            check($sformatf("vec%0d_cv", v), int'(bus.commit_value), vecs[v].exp_cv);
            check($sformatf("vec%0d_err", v), ter, vecs[v].exp_err);
        end

        // Single press: accepted on the third frame, no repeat while held
        do_reset();
        for (int f = 0; f < 3; f++) begin
            run_frame(kmask(5), kv, cm, er);
            check($sformatf("single_f%0d", f), kv, (f == 2) ? 1 : 0);
        end
        check("single_code", int'(bus.key_code), 5);
        check("single_entry", int'(bus.entry), 'h5);
        check("single_len", int'(bus.entry_len), 1);
        tkv = 0;
        for (int f = 0; f < 5; f++) begin
            run_frame(kmask(5), kv, cm, er);
            tkv += kv;
        end
        check("single_hold", tkv, 0);

        // Press bounce then release bounce
        do_reset();
        for (int f = 0; f < 5; f++) begin
            run_frame((f == 1) ? 12'h000 : kmask(8), kv, cm, er);
            check($sformatf("bounce_f%0d", f), kv, (f == 4) ? 1 : 0);
        end
        tkv = 0;
        for (int f = 0; f < 5; f++) begin
            run_frame((f == 1) ? kmask(8) : 12'h000, kv, cm, er);
            tkv += kv;
        end
        check("rel_bounce", tkv, 0);
        for (int f = 0; f < 3; f++) begin
            run_frame(kmask(8), kv, cm, er);
            check($sformatf("repress_f%0d", f), kv, (f == 2) ? 1 : 0);
        end
        check("repress_entry", int'(bus.entry), 'h88);

        // Ghosting across columns and two rows in one column
        do_reset();
        tkv = 0;
        for (int f = 0; f < 4; f++) begin
            run_frame(kmask(1) | kmask(3), kv, cm, er);
            tkv += kv;
        end
        for (int f = 0; f < 4; f++) begin
            run_frame(kmask(1) | kmask(4), kv, cm, er);
            tkv += kv;
        end
        check("ghost_valid", tkv, 0);
        check("ghost_code", int'(bus.key_code), 15);

        // Reset in the middle of a debounce restarts the count
        tkv = 0;
        for (int f = 0; f < 3; f++) begin
            run_frame(12'h000, kv, cm, er);
            tkv += kv;
        end
        for (int f = 0; f < 2; f++) begin
            run_frame(kmask(9), kv, cm, er);
            tkv += kv;
        end
        repeat (5) begin
            @(posedge fin);
            @(negedge fin);
        end
        rst = 1'b1;
        repeat (2) @(negedge fin);
        rst = 1'b0;
        check("rstdeb_pre", tkv, 0);
        check("rstdeb_code", int'(bus.key_code), 15);
        for (int f = 0; f < 3; f++) begin
            run_frame(kmask(9), kv, cm, er);
            check($sformatf("rstdeb_f%0d", f), kv, (f == 2) ? 1 : 0);
        end
        check("rstdeb_entry", int'(bus.entry), 'h9);

        // Randomized key activity against the model
        do_reset();
        model_reset();
        cur = '0;
        for (int f = 0; f < 400; f++) begin
            int r, k1, k2;
            r = $urandom_range(0, 99);
            if (r >= 70) begin
                if (r < 82) cur = '0;
                else if (r < 96) cur = kmask($urandom_range(0, 11));
                else begin
                    k1 = $urandom_range(0, 11);
                    k2 = (k1 + $urandom_range(1, 11)) % 12;
                    cur = kmask(k1) | kmask(k2);
                end
            end
            model_frame(cur, acc, ecm, eer);
            run_frame(cur, kv, cm, er);
            check("rnd_valid", kv, acc);
            check("rnd_commit", cm, ecm);
            check("rnd_err", er, eer);
            check("rnd_code", int'(bus.key_code), m_code);
            check("rnd_entry", int'(bus.entry), m_entry());
            check("rnd_len", int'(bus.entry_len), m_q.size());
            check("rnd_cv", int'(bus.commit_value), m_cv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
